hazard_scoreboard: RTL

Producer-side companion to the operand forwarding unit in the 5-stage pipeline. It tracks the destination tag (register number, write-enable, load flag) of each instruction as it moves through EX, MEM and WB, and drives the tags that forwarding consumes. It detects load-use hazards that forwarding cannot cover and generates the stall and bubble controls for the fetch, decode and execute boundary. It also applies whole-pipe freeze on memory wait and kill on branch flush, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_scoreboard_if.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_if : decode-side request and hazard/tag response bundle
// Revision: 1.0
// ============================================================================

interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  // Decode-stage instruction and pipeline control, driven by the controller
  logic             ID_VALID;
  logic [4:0]       RS;
  logic [4:0]       RT;
  logic             USES_RS;
  logic             USES_RT;
  logic [4:0]       RD;
  logic             WB_EN;
  logic             MEM_READ;
  logic             FLUSH;
  logic             MEM_READY;

  // Hazard controls and in-flight destination tags, driven by the scoreboard
  logic             STALL;
  logic             BUBBLE;
  logic             WB_EN_EX;
  logic [4:0]       RD_EX;
  logic             MEM_READ_EX;
  logic             WB_EN_MEM;
  logic [4:0]       RD_MEM;
  logic             WB_EN_WB;
  logic [4:0]       RD_WB;
  logic [CNT_W-1:0] STALL_CYCLES;

  modport master (
    output ID_VALID, RS, RT, USES_RS, USES_RT, RD, WB_EN, MEM_READ, FLUSH, MEM_READY,
    input  STALL, BUBBLE, WB_EN_EX, RD_EX, MEM_READ_EX, WB_EN_MEM, RD_MEM,
           WB_EN_WB, RD_WB, STALL_CYCLES
  );

  modport slave (
    input  ID_VALID, RS, RT, USES_RS, USES_RT, RD, WB_EN, MEM_READ, FLUSH, MEM_READY,
    output STALL, BUBBLE, WB_EN_EX, RD_EX, MEM_READ_EX, WB_EN_MEM, RD_MEM,
           WB_EN_WB, RD_WB, STALL_CYCLES
  );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard : EX/MEM/WB destination tag tracking, load-use stall and
//                     bubble generation, memory freeze, flush, stall counter.
// Revision: 1.0
// ============================================================================

module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic       wb_en;
    logic [4:0] rd;
    logic       mem_read;
  } ex_tag_t;

  // Past EX only the write tag matters to forwarding.
  typedef struct packed {
    logic       wb_en;
    logic [4:0] rd;
  } ret_tag_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ex_tag_t          ex_q, ex_d, dec_tag;
  ret_tag_t         mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_live, rs_hit, rt_hit, load_use;
  logic             stall, bubble;

  // An invalid decode slot enters EX as an all-zero NOP tag.
  always_comb begin
    dec_tag = '0;
    if (bus.ID_VALID) begin
      dec_tag.wb_en    = bus.WB_EN;
      dec_tag.rd       = bus.RD;
      dec_tag.mem_read = bus.MEM_READ;
    end
  end

  assign ex_live  = ex_q.wb_en && (ex_q.rd != 5'd0);
  assign rs_hit   = bus.USES_RS && (bus.RS == ex_q.rd);
  assign rt_hit   = bus.USES_RT && (bus.RT == ex_q.rd);
  assign load_use = bus.ID_VALID && ex_live && ex_q.mem_read && (rs_hit || rt_hit);

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    ex_d   = ex_q;
    mem_d  = mem_q;
    wb_d   = wb_q;
    cnt_d  = cnt_q;
    if (!bus.MEM_READY) begin
      stall = 1'b1;
    end else begin
      mem_d.wb_en = ex_q.wb_en;
      mem_d.rd    = ex_q.rd;
      wb_d        = mem_q;
      ex_d        = '0;
      if (bus.FLUSH) begin
        bubble = 1'b1;
      end else if (load_use) begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        ex_d = dec_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.STALL        = stall;
  assign bus.BUBBLE       = bubble;
  assign bus.WB_EN_EX     = ex_q.wb_en;
  assign bus.RD_EX        = ex_q.rd;
  assign bus.MEM_READ_EX  = ex_q.mem_read;
  assign bus.WB_EN_MEM    = mem_q.wb_en;
  assign bus.RD_MEM       = mem_q.rd;
  assign bus.WB_EN_WB     = wb_q.wb_en;
  assign bus.RD_WB        = wb_q.rd;
  assign bus.STALL_CYCLES = cnt_q;

endmodule

`default_nettype wire
